// File: rtl/adder_pkg.sv
// adder_pkg: shared types and helpers for the pipelined adder/subtractor.
// Build option: define ADDER_FLAGS_EN to add the NZCV flags port to pipelined_adder.
package adder_pkg;

    // NZCV flags in ARM order, MSB first.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // Bit positions of each flag inside a 4-bit flags vector.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Width of one carry-chain slice (one slice per pipeline stage).
    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice: combinational S-bit ripple of full-adder cells with carry in/out.
// One instance per pipeline stage; the carry out is registered by the caller.
module adder_slice #(
    parameter int S = 16
) (
    input  logic [S-1:0] a,
    input  logic [S-1:0] b,
    input  logic         cin,
    output logic [S-1:0] sum,
    output logic         cout
);

    logic [S:0] carry_s;

    // Ripple the carry through S full-adder cells.
    always_comb begin
        carry_s    = '0;
        sum        = '0;
        carry_s[0] = cin;
        for (int i = 0; i < S; i++) begin
            sum[i]         = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i + 1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry_s[S];

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract with the carry chain split into STAGES
// slices, one per pipeline stage, behind a valid/ready handshake.
// Build option: ADDER_FLAGS_EN adds the registered NZCV flags output.
// Stage k register holds the finished low (k+1)*S sum bits, the carry out of
// slice k, and the operand bits that have not been added yet. Slice 0 sits in
// front of the first register, so the last register holds the complete result.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef ADDER_FLAGS_EN
    output logic [3:0]       flags,
`endif
    output logic [WIDTH-1:0] sum
);

    localparam int S = slice_w(WIDTH, STAGES);

    if ((WIDTH % STAGES) != 0) begin : g_chk_div
        $error("pipelined_adder: WIDTH %0d is not divisible by STAGES %0d", WIDTH, STAGES);
    end
    if ((STAGES < 1) || (STAGES > WIDTH)) begin : g_chk_range
        $error("pipelined_adder: STAGES %0d out of range 1..WIDTH", STAGES);
    end

    logic             adv_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             out_valid_r;
    logic [WIDTH-1:0] sum_r;

    // The whole pipe moves together unless a finished result is being held.
    assign adv_s    = !out_valid_r || out_ready;
    assign in_ready = adv_s;

    // Subtraction is A + ~B + cin; the caller supplies cin = 1 for a plain SUB.
    always_comb begin
        if (sub) begin
            b_eff_s = ~b;
        end else begin
            b_eff_s = b;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int REM  = WIDTH - (k * S);   // operand bits not yet added
        localparam int DONE = (k + 1) * S;       // sum bits finished after this slice

        logic            v_s;
        logic            c_s;
        logic [REM-1:0]  a_s;
        logic [REM-1:0]  b_s;
        logic [S-1:0]    ssum_s;
        logic            cout_s;
        logic [DONE-1:0] acc_s;

        if (k == 0) begin : g_src
            assign v_s   = in_valid;
            assign c_s   = cin;
            assign a_s   = a;
            assign b_s   = b_eff_s;
            assign acc_s = ssum_s;
        end else begin : g_src
            assign v_s   = g_stage[k-1].g_reg.v_r;
            assign c_s   = g_stage[k-1].g_reg.c_r;
            assign a_s   = g_stage[k-1].g_reg.a_r;
            assign b_s   = g_stage[k-1].g_reg.b_r;
            assign acc_s = {ssum_s, g_stage[k-1].g_reg.acc_r};
        end

        adder_slice #(
            .S(S)
        ) u_slice (
            .a    (a_s[S-1:0]),
            .b    (b_s[S-1:0]),
            .cin  (c_s),
            .sum  (ssum_s),
            .cout (cout_s)
        );

        if (k < (STAGES - 1)) begin : g_reg
            logic              v_r;
            logic              c_r;
            logic [REM-S-1:0]  a_r;
            logic [REM-S-1:0]  b_r;
            logic [DONE-1:0]   acc_r;

            // Intermediate stage register: shifts on adv, holds on stall.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    v_r   <= 1'b0;
                    c_r   <= 1'b0;
                    a_r   <= '0;
                    b_r   <= '0;
                    acc_r <= '0;
                end else if (adv_s) begin
                    v_r   <= v_s;
                    c_r   <= cout_s;
                    a_r   <= a_s[REM-1:S];
                    b_r   <= b_s[REM-1:S];
                    acc_r <= acc_s;
                end
            end
        end
    end

    logic [WIDTH-1:0] last_sum_s;
    assign last_sum_s = g_stage[STAGES-1].acc_s;

    // Final stage register: drives out_valid and sum directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            sum_r       <= '0;
        end else if (adv_s) begin
            out_valid_r <= g_stage[STAGES-1].v_s;
            sum_r       <= last_sum_s;
        end
    end

    assign out_valid = out_valid_r;
    assign sum       = sum_r;

`ifdef ADDER_FLAGS_EN
    logic   last_cout_s;
    logic   last_a_msb_s;
    logic   last_b_msb_s;
    flags_t flags_s;
    flags_t flags_r;

    assign last_cout_s  = g_stage[STAGES-1].cout_s;
    assign last_a_msb_s = g_stage[STAGES-1].a_s[S-1];
    assign last_b_msb_s = g_stage[STAGES-1].b_s[S-1];

    // NZCV from the completed sum and the operand sign bits seen by the last slice.
    always_comb begin
        flags_s   = '0;
        flags_s.n = last_sum_s[WIDTH-1];
        flags_s.z = (last_sum_s == '0);
        flags_s.c = last_cout_s;
        if ((last_a_msb_s == last_b_msb_s) && (last_sum_s[WIDTH-1] != last_a_msb_s)) begin
            flags_s.v = 1'b1;
        end else begin
            flags_s.v = 1'b0;
        end
    end

    // Flag register, loaded on the same edges as sum_r so the two stay aligned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_r <= '0;
        end else if (adv_s) begin
            flags_r <= flags_s;
        end
    end

    assign flags = flags_r;
`else
    // The final carry is computed but only feeds the flags when they are built in.
    logic unused_cout_s;
    assign unused_cout_s = g_stage[STAGES-1].cout_s;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed corner cases, a random
// back-to-back stream, a stall, a mid-stream reset and latency checks for
// STAGES = 1 and STAGES = WIDTH on 8-bit instances. Flags are checked when
// ADDER_FLAGS_EN is defined.
module tb_pipelined_adder;

    localparam int W   = 64;
    localparam int STG = 4;

    typedef struct {
        logic [63:0] sum;
        logic [3:0]  flags;
        int          t;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   a;
    logic [63:0]   b;
    logic          sub;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   sum;

    logic          s_valid;
    logic [7:0]    s_a;
    logic [7:0]    s_b;
    logic          s_cin;
    logic          o1_in_ready;
    logic          o1_valid;
    logic [7:0]    o1_sum;
    logic          o8_in_ready;
    logic          o8_valid;
    logic [7:0]    o8_sum;

`ifdef ADDER_FLAGS_EN
    logic [3:0]    flags;
    logic [3:0]    o1_flags;
    logic [3:0]    o8_flags;
`endif

    int   total  = 0;
    int   passed = 0;
    int   fails  = 0;
    int   cyc    = 0;
    bit   lat_chk = 1'b1;
    bit   ovr_v   = 1'b0;
    exp_t ovr;
    exp_t q[$];

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(STG)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
`ifdef ADDER_FLAGS_EN
        .flags(flags),
`endif
        .sum(sum)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(s_valid), .in_ready(o1_in_ready),
        .a(s_a), .b(s_b), .sub(1'b0), .cin(s_cin), .out_valid(o1_valid), .out_ready(1'b1),
`ifdef ADDER_FLAGS_EN
        .flags(o1_flags),
`endif
        .sum(o1_sum)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .in_valid(s_valid), .in_ready(o8_in_ready),
        .a(s_a), .b(s_b), .sub(1'b0), .cin(s_cin), .out_valid(o8_valid), .out_ready(1'b1),
`ifdef ADDER_FLAGS_EN
        .flags(o8_flags),
`endif
        .sum(o8_sum)
    );

    // Reference: whole-word arithmetic. V is signed overflow of the true sum.
    function automatic exp_t model(input logic [63:0] x, input logic [63:0] y,
                                   input logic s, input logic c);
        exp_t               m;
        logic [63:0]        yb;
        logic [64:0]        u;
        logic signed [65:0] sg;
        logic               v;
        yb = s ? ~y : y;
        u  = {1'b0, x} + {1'b0, yb} + 65'(c);
        sg = $signed({{2{x[63]}}, x}) + $signed({{2{yb[63]}}, yb}) + $signed({65'd0, c});
        v  = (sg[65:63] != 3'b000) && (sg[65:63] != 3'b111);
        m.sum   = u[63:0];
        m.flags = {u[63], (u[63:0] == 64'd0), u[64], v};
        m.t     = 0;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: score completion and acceptance just before the edge, then step.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            chk("result_expected", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sum", sum, e.sum);
`ifdef ADDER_FLAGS_EN
                chk("flags", 64'(flags), 64'(e.flags));
`endif
                if (lat_chk) chk("latency", 64'(cyc - e.t), 64'(STG - 1));
            end
        end
        if (in_valid && in_ready) begin
            if (ovr_v) begin
                e     = ovr;
                ovr_v = 1'b0;
            end else begin
                e = model(a, b, sub, cin);
            end
            e.t = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic rand_ops();
        a   = {$urandom, $urandom};
        b   = {$urandom, $urandom};
        sub = 1'($urandom_range(0, 1));
        cin = 1'($urandom_range(0, 1));
    endtask

    task automatic directed(input logic [63:0] x, input logic [63:0] y, input logic s,
                            input logic c, input logic [63:0] es, input logic [3:0] ef);
        a = x; b = y; sub = s; cin = c; in_valid = 1'b1;
        ovr.sum = es; ovr.flags = ef; ovr.t = 0; ovr_v = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] hold_sum;
        logic [3:0]  hold_flags;
        int          lat1;
        int          lat8;
        logic [7:0]  r1_sum;
        logic [7:0]  r8_sum;
        logic [3:0]  r1_flags;
        logic [3:0]  r8_flags;

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        s_valid = 1'b0; s_a = 8'h00; s_b = 8'h00; s_cin = 1'b0;
        hold_flags = 4'h0; r1_flags = 4'h0; r8_flags = 4'h0;
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", sum, 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef ADDER_FLAGS_EN
        chk("rst_flags", 64'(flags), 64'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed corner cases, issued back to back.
        directed(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 4'b0110);
        directed(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 4'b1001);
        directed(64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);
        directed(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 64'd1, 4'b0011);
        directed(64'd9, 64'd9, 1'b1, 1'b1, 64'd0, 4'b0110);
        drain();

        // Back-to-back random stream; per-result latency check proves no gaps.
        for (int i = 0; i < 16; i++) begin
            rand_ops();
            in_valid = 1'b1;
            tick();
        end
        drain();

        // Stall with a full pipe.
        for (int i = 0; i < STG; i++) begin
            rand_ops();
            in_valid = 1'b1;
            tick();
        end
        lat_chk   = 1'b0;
        out_ready = 1'b0;
        hold_sum  = sum;
`ifdef ADDER_FLAGS_EN
        hold_flags = flags;
`endif
        for (int i = 0; i < 5; i++) begin
            rand_ops();
            in_valid = 1'b1;
            #1;
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_sum", sum, hold_sum);
`ifdef ADDER_FLAGS_EN
            chk("stall_flags", 64'(flags), 64'(hold_flags));
`endif
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            in_valid = 1'b1;
            tick();
        end
        drain();
        lat_chk = 1'b1;

        // Reset with one result at the output and three behind it.
        for (int i = 0; i < STG; i++) begin
            rand_ops();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_sum", sum, 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
`ifdef ADDER_FLAGS_EN
        chk("midrst_flags", 64'(flags), 64'd0);
`endif
        q.delete();
        #7;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("no_stale", 64'(out_valid), 64'd0);
            tick();
        end
        rand_ops();
        in_valid = 1'b1;
        tick();
        drain();

        // Latency at the STAGES extremes on 8-bit instances.
        lat1 = 0; lat8 = 0; r1_sum = 8'h00; r8_sum = 8'h00;
        s_a = 8'h80; s_b = 8'h80; s_cin = 1'b1; s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (o1_valid && lat1 == 0) begin
                lat1 = i; r1_sum = o1_sum;
`ifdef ADDER_FLAGS_EN
                r1_flags = o1_flags;
`endif
            end
            if (o8_valid && lat8 == 0) begin
                lat8 = i; r8_sum = o8_sum;
`ifdef ADDER_FLAGS_EN
                r8_flags = o8_flags;
`endif
            end
            @(posedge clk);
            #1;
        end
        chk("stages1_latency", 64'(lat1), 64'd1);
        chk("stages8_latency", 64'(lat8), 64'd8);
        chk("stages1_sum", 64'(r1_sum), 64'h01);
        chk("stages8_sum", 64'(r8_sum), 64'h01);
`ifdef ADDER_FLAGS_EN
        chk("stages1_flags", 64'(r1_flags), 64'b0011);
        chk("stages8_flags", 64'(r8_flags), 64'b0011);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
